dmem_ctrl: RTL

Multi-cycle data-memory controller sitting directly downstream of the EX stage, in place of the single-cycle data array inside the MEM stage. It accepts one word read or write per request from the EX/MEM pipeline register and models a memory with configurable access latency. It stalls the pipeline until the access completes, then returns read data to the MEM/WB path. It also flags misaligned and out-of-range accesses and counts stall cycles for performance analysis.

---
 rtl/dmem_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller with configurable access latency.
// Stalls the pipeline for the access, flags illegal addresses and counts stall cycles.
module dmem_ctrl #(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read_En,
   input  logic        write_En,
   input  logic [31:0] DataAddress,
   input  logic [31:0] WriteData,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        err,
   output logic [15:0] stall_cnt
);

   // state | meaning
   // IDLE  | waiting for a request; legal requests stall combinationally
   // BUSY  | counting down the access latency, access happens at cnt == 0
   // DONE  | access finished, stall released, held request is ignored
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [3:0]      CNT_LOAD = 4'(LATENCY - 1);
   localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              wr_q;
   logic [ADDR_W-1:0] idx_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              rvalid_q;
   logic              err_q;
   logic [15:0]       stall_cnt_q;
   logic [15:0]       stall_cnt_d;
   logic [31:0]       mem [DEPTH];

   logic              req;
   logic [ADDR_W-1:0] idx;
   logic              legal;
   logic              accept;

   assign req    = read_En | write_En;
   assign idx    = DataAddress[ADDR_W+1:2];
   assign legal  = (DataAddress[1:0] == 2'b00) &&
                   (DataAddress[31:ADDR_W+2] == '0) &&
                   ({1'b0, idx} < DEPTH_W);
   assign accept = (state_q == IDLE) && req && legal;

   assign stall       = !reset && (accept || (state_q == BUSY));
   assign stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         rvalid_q    <= 1'b0;
         err_q       <= 1'b0;
         stall_cnt_q <= stall_cnt_d;
         case (state_q)
            IDLE: begin
               if (req) begin
                  if (legal) begin
                     wr_q    <= write_En;
                     idx_q   <= idx;
                     wdata_q <= WriteData;
                     cnt_q   <= CNT_LOAD;
                     state_q <= BUSY;
                  end else begin
                     err_q <= 1'b1;
                     // a rejected load still completes, with zero data
                     if (!write_En) begin
                        rdata_q  <= '0;
                        rvalid_q <= 1'b1;
                     end
                  end
               end
            end
            BUSY: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  if (!wr_q) begin
                     rdata_q  <= mem[idx_q];
                     rvalid_q <= 1'b1;
                  end
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // array is not reset; a reset during BUSY forces IDLE so no write happens
   always_ff @(posedge clk) begin
      if ((state_q == BUSY) && (cnt_q == 4'd0) && wr_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign rdata       = rdata_q;
   assign rdata_valid = rvalid_q;
   assign err         = err_q;
   assign stall_cnt   = stall_cnt_q;

endmodule
